// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU. Single-cycle logic/arith ops, signed SLT with
// overflow correction, and multi-cycle unsigned MULTU/DIVU into internal HI/LO.
// Optional feature: define ALU_DIV_EN to build the restoring divider (DIVU).
// Without it, DIVU decodes as an undefined opcode.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready to accept an operation (in_ready = 1)
// MUL   | shift-add multiply, one iteration per clock
// DIV   | restoring divide, one iteration per clock (ALU_DIV_EN only)
// DONE  | result held with out_valid = 1 until out_ready
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1001;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;   // MUL: {partial hi, multiplier/lo}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   mcand;  // multiplicand or divisor
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic [WIDTH-1:0]   a_opd, b_opd;
  logic [WIDTH:0]     sum_ext;
  logic               carry_msb, add_ovf, slt_bit;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_ovf;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign in_ready      = (state == S_IDLE);
  assign out_valid     = (state == S_DONE);
  assign zero_flag     = (result == '0);
  assign negative_flag = result[WIDTH-1];

  // Shared adder: op[3]/op[2] invert A/B, binvert doubles as carry-in for subtract
  always_comb begin
    a_opd     = op[3] ? ~operand_a : operand_a;
    b_opd     = op[2] ? ~operand_b : operand_b;
    sum_ext   = {1'b0, a_opd} + {1'b0, b_opd} + {{WIDTH{1'b0}}, op[2]};
    carry_msb = sum_ext[WIDTH-1] ^ a_opd[WIDTH-1] ^ b_opd[WIDTH-1];
    add_ovf   = carry_msb ^ sum_ext[WIDTH];
    slt_bit   = sum_ext[WIDTH-1] ^ add_ovf;
  end

  // Single-cycle result decode; undefined opcodes fall through to zero
  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (op)
      OP_AND:         sc_result = operand_a & operand_b;
      OP_OR:          sc_result = operand_a | operand_b;
      OP_ADD, OP_SUB: begin
        sc_result = sum_ext[WIDTH-1:0];
        sc_ovf    = add_ovf;
      end
      OP_SLT:         sc_result = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOR:         sc_result = ~(operand_a | operand_b);
      OP_MFHI:        sc_result = hi;
      OP_MFLO:        sc_result = lo;
      default:        sc_result = '0;
    endcase
  end

  // One shift-add multiply step: add multiplicand into the top half when lsb set, then shift right
  always_comb begin
    mul_addend = prod[0] ? mcand : {WIDTH{1'b0}};
    mul_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, prod[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;

  // One restoring divide step: shift next dividend bit into remainder, subtract if it fits
  always_comb begin
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (!div_diff[WIDTH])
      div_next = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
  end
`endif

  // Control FSM with registered result, overflow flag and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      prod          <= '0;
      mcand         <= '0;
      hi            <= '0;
      lo            <= '0;
      result        <= '0;
      overflow_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cnt           <= '0;
            overflow_flag <= 1'b0;
            if (op == OP_MULTU) begin
              prod  <= {{WIDTH{1'b0}}, operand_b};
              mcand <= operand_a;
              state <= S_MUL;
            end
`ifdef ALU_DIV_EN
            else if (op == OP_DIVU && operand_b == '0) begin
              hi     <= operand_a;
              lo     <= '1;
              result <= '1;
              state  <= S_DONE;
            end else if (op == OP_DIVU) begin
              prod  <= {{WIDTH{1'b0}}, operand_a};
              mcand <= operand_b;
              state <= S_DIV;
            end
`endif
            else begin
              result        <= sc_result;
              overflow_flag <= sc_ovf;
              state         <= S_DONE;
            end
          end
        end
        S_MUL: begin
          cnt  <= cnt + CNT_W'(1);
          prod <= mul_next;
          if (cnt == CNT_LAST) begin
            hi     <= mul_next[2*WIDTH-1:WIDTH];
            lo     <= mul_next[WIDTH-1:0];
            result <= mul_next[WIDTH-1:0];
            state  <= S_DONE;
          end
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          cnt  <= cnt + CNT_W'(1);
          prod <= div_next;
          if (cnt == CNT_LAST) begin
            hi     <= div_next[2*WIDTH-1:WIDTH];
            lo     <= div_next[WIDTH-1:0];
            result <= div_next[WIDTH-1:0];
            state  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a queue scoreboard and a separate
// output monitor. Expected DIVU behaviour follows the ALU_DIV_EN build setting.
module tb_alu_seq;
  localparam int W = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;
  localparam logic [3:0] OP_UNDEF = 4'b0011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero_flag;
  logic         negative_flag;
  logic         overflow_flag;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int next_id = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         n;
    logic         v;
    logic         zchk;
    int           lat;
    int           acc;
    int           id;
  } exp_t;

  exp_t sbq[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero_flag(zero_flag),
    .negative_flag(negative_flag),
    .overflow_flag(overflow_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int id, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s #%0d got %h expected %h", nm, id, act, req);
    end
  endtask

  // Offer one op at posedge+1; push the expected response when push is set
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] res, input logic n, input logic v,
                       input logic zchk, input int lat);
    int t;
    exp_t e;
    t = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 expected in_ready=1");
      return;
    end
    in_valid  = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    if (push) begin
      e.res  = res;
      e.n    = n;
      e.v    = v;
      e.zchk = zchk;
      e.lat  = lat;
      e.acc  = cyc + 1;
      e.id   = next_id;
      next_id++;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: latency, hold stability, busy in_ready, and scoreboard compare on handoff
  initial begin : monitor
    exp_t         e;
    bit           seen;
    bit           hold;
    int           first;
    logic [W-1:0] pr;
    logic         pz, pn, pv;
    seen = 0; hold = 0; first = 0; pr = '0; pz = 0; pn = 0; pv = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
        hold = 0;
      end else if (out_valid) begin
        if (!seen) begin
          seen  = 1;
          first = cyc;
        end
        chk("in_ready_busy", -1, W'(in_ready), W'(0));
        if (hold) begin
          chk("hold_result", -1, result, pr);
          chk("hold_zero", -1, W'(zero_flag), W'(pz));
          chk("hold_neg", -1, W'(negative_flag), W'(pn));
          chk("hold_ovf", -1, W'(overflow_flag), W'(pv));
        end
        hold = !out_ready;
        pr = result; pz = zero_flag; pn = negative_flag; pv = overflow_flag;
        if (out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got %h expected none", result);
          end else begin
            e = sbq.pop_front();
            chk("result", e.id, result, e.res);
            if (e.zchk) chk("zero", e.id, W'(zero_flag), W'(e.res == '0));
            chk("negative", e.id, W'(negative_flag), W'(e.n));
            chk("overflow", e.id, W'(overflow_flag), W'(e.v));
            chk("latency", e.id, W'(first - e.acc), W'(e.lat));
          end
          seen = 0;
        end
      end else begin
        hold = 0;
      end
    end
  end

  initial begin : stim
    int t;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; operand_a = '0; operand_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", -1, W'(out_valid), W'(0));
    chk("reset_in_ready", -1, W'(in_ready), W'(1));
    chk("reset_result", -1, result, W'(0));
    chk("reset_flags", -1, W'({zero_flag & 1'b0, negative_flag, overflow_flag}), W'(0));
    rst_n = 1'b1;

    // Single-cycle arithmetic and logic
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1, 1, 1, 0);
    issue(OP_SUB, 32'd5, 32'd5, 1, 32'h0, 0, 0, 1, 0);
    issue(OP_SLT, 32'h8000_0000, 32'h0000_0001, 1, 32'h1, 0, 0, 1, 0);
    issue(OP_SLT, 32'h0000_0001, 32'h8000_0000, 1, 32'h0, 0, 0, 1, 0);
    issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, 0, 0, 1, 0);
    issue(OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'hFFF0_FF34, 1, 0, 1, 0);
    issue(OP_NOR, 32'h0000_FFFF, 32'h00FF_0000, 1, 32'hFF00_0000, 1, 0, 1, 0);
    issue(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 0, 1, 1, 0);
    issue(OP_UNDEF, 32'd5, 32'd3, 1, 32'h0, 0, 0, 0, 0);

    // Multiply into HI/LO
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0001, 0, 0, 1, W);
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'hFFFF_FFFE, 1, 0, 1, 0);
    issue(OP_MULTU, 32'h8000_0000, 32'h0000_0004, 1, 32'h0, 0, 0, 1, W);
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'h0000_0002, 0, 0, 1, 0);
    issue(OP_MULTU, 32'h0001_2345, 32'h0000_0100, 1, 32'h0123_4500, 0, 0, 1, W);
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'h0, 0, 0, 1, 0);

    // Divide (or undefined-op behaviour when the divider is not built)
`ifdef ALU_DIV_EN
    issue(OP_DIVU, 32'd100, 32'd7, 1, 32'd14, 0, 0, 1, W);
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'd2, 0, 0, 1, 0);
    issue(OP_MFLO, 32'h0, 32'h0, 1, 32'd14, 0, 0, 1, 0);
    issue(OP_DIVU, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 1, 0, 1, 0);
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'd9, 0, 0, 1, 0);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 1, 32'h0FFF_FFFF, 0, 0, 1, W);
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'h0000_000F, 0, 0, 1, 0);
`else
    issue(OP_DIVU, 32'd100, 32'd7, 1, 32'h0, 0, 0, 0, 0);
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'h0, 0, 0, 1, 0);
    issue(OP_MFLO, 32'h0, 32'h0, 1, 32'h0123_4500, 0, 0, 1, 0);
    issue(OP_DIVU, 32'd9, 32'd0, 1, 32'h0, 0, 0, 0, 0);
    issue(OP_MFLO, 32'h0, 32'h0, 1, 32'h0123_4500, 0, 0, 1, 0);
`endif

    // Backpressure: hold result, ignore offered ops, then release
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(OP_ADD, 32'd3, 32'd4, 1, 32'd7, 0, 0, 1, 0);
    repeat (5) begin
      in_valid = 1'b1; op = OP_OR; operand_a = 32'hAAAA_0000; operand_b = 32'h0000_5555;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_out_valid", -1, W'(out_valid), W'(0));
    chk("release_in_ready", -1, W'(in_ready), W'(1));
    issue(OP_OR, 32'h0000_00F0, 32'h0000_000F, 1, 32'h0000_00FF, 0, 0, 1, 0);

    // Load HI with a known non-zero value, then abort a multiply with reset
    issue(OP_MULTU, 32'h0001_0000, 32'h0003_0000, 1, 32'h0, 0, 0, 1, W);
    issue(OP_MULTU, 32'd3, 32'd5, 0, 32'h0, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("abort_out_valid", -1, W'(out_valid), W'(0));
    chk("abort_result", -1, result, W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", -1, W'(in_ready), W'(1));
    chk("post_reset_out_valid", -1, W'(out_valid), W'(0));
    chk("post_reset_result", -1, result, W'(0));
    repeat (40) @(posedge clk);
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'h0, 0, 0, 1, 0);
    issue(OP_MFLO, 32'h0, 32'h0, 1, 32'h0, 0, 0, 1, 0);

    t = 0;
    while (sbq.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expected 0", sbq.size());
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
